// File: rtl/led_sweep_controller.sv
// led_sweep_controller
// AMCI master that sweeps one lit LED across the low LED_WIDTH bits of the
// GPIO LED register. It starts on a debounced button press and restores the
// original register value at the end. A second press aborts the sweep early.
// Response errors are captured in a sticky flag.

module led_sweep_controller #(
  parameter int                        AXI_DATA_WIDTH  = 32,
  parameter int                        AXI_ADDR_WIDTH  = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] LED_ADDR        = 32'h4000_0000,
  parameter int                        LED_WIDTH       = 4,
  parameter int                        PASSES          = 2,
  parameter int                        STEP_CYCLES     = 25_000_000,
  parameter int                        DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                                        CLK,
  input  logic                                        RESETN,
  input  logic                                        BUTTON,
  output logic [2*AXI_ADDR_WIDTH+AXI_DATA_WIDTH+1:0]  AMCI_MOSI,
  input  logic [AXI_DATA_WIDTH+5:0]                   AMCI_MISO,
  output logic                                        BUSY,
  output logic                                        ERROR,
  output logic                                        DONE
);

  localparam int DW     = AXI_DATA_WIDTH;
  localparam int AW     = AXI_ADDR_WIDTH;
  localparam int BIT_W  = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(LED_WIDTH - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  // Ones in the swept bit positions. These bits are cleared before one of them is lit.
  localparam logic [DW-1:0] LED_MASK = {DW{1'b1}} >> (DW - LED_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    HOLD,
    RS_REQ,
    RS_WAIT
  } state_t;

  state_t state;
  state_t state_next;

  // Engine response fields
  logic [DW-1:0] rdata;
  logic          widle;
  logic          ridle;
  logic [1:0]    wresp;
  logic [1:0]    rresp;

  assign rdata = AMCI_MISO[DW-1:0];
  assign widle = AMCI_MISO[DW];
  assign ridle = AMCI_MISO[DW+1];
  assign wresp = AMCI_MISO[DW+3:DW+2];
  assign rresp = AMCI_MISO[DW+5:DW+4];

  // Button conditioning
  logic             sync_meta;
  logic             sync_btn;
  logic             deb_level;
  logic             deb_prev;
  logic [DEB_W-1:0] deb_cnt;
  logic             press;

  // Sequencer datapath registers and their next values
  logic [BIT_W-1:0]  bit_idx,       bit_next;
  logic [PASS_W-1:0] pass_idx,      pass_next;
  logic [STEP_W-1:0] step_cnt,      step_next;
  logic [DW-1:0]     saved,         saved_next;
  logic              abort_pending, abort_next;
  logic              error_q,       error_next;
  logic              settle;
  logic              done_q;
  logic [AW-1:0]     raddr_q;
  logic [AW-1:0]     waddr_q;
  logic [DW-1:0]     wdata_q;

  // Bus-facing values for the current cycle
  logic          read_stb;
  logic          write_stb;
  logic [AW-1:0] raddr_out;
  logic [AW-1:0] waddr_out;
  logic [DW-1:0] wdata_out;
  logic [DW-1:0] led_word;

  // Bring the raw button into the clock domain through two flops
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sync_meta <= 1'b0;
      sync_btn  <= 1'b0;
    end else begin
      sync_meta <= BUTTON;
      sync_btn  <= sync_meta;
    end
  end

  // Update the debounced level after DEBOUNCE_CYCLES consecutive disagreeing clocks
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      deb_prev <= deb_level;
      if (sync_btn != deb_level) begin
        if (deb_cnt == DEB_LAST) begin
          deb_level <= sync_btn;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // A press is the single cycle in which the debounced level has just risen
  assign press = deb_level & ~deb_prev;

  // State register
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, bus strobes and datapath updates. Presses in RD_* and RS_* states are ignored.
  always_comb begin
    state_next = state;
    bit_next   = bit_idx;
    pass_next  = pass_idx;
    step_next  = step_cnt;
    saved_next = saved;
    abort_next = abort_pending;
    error_next = error_q;
    read_stb   = 1'b0;
    write_stb  = 1'b0;
    raddr_out  = raddr_q;
    waddr_out  = waddr_q;
    wdata_out  = wdata_q;
    led_word   = (saved & ~LED_MASK) | (DW'(1) << bit_idx);

    case (state)
      IDLE: begin
        if (press) begin
          state_next = RD_REQ;
          bit_next   = '0;
          pass_next  = '0;
          abort_next = 1'b0;
        end
      end

      RD_REQ: begin
        raddr_out = LED_ADDR;
        if (ridle) begin
          read_stb   = 1'b1;
          state_next = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (!settle && ridle) begin
          saved_next = rdata;
          if (rresp != 2'b00) begin
            error_next = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WR_REQ;
          end
        end
      end

      WR_REQ: begin
        if (press || abort_pending) begin
          state_next = RS_REQ;
        end else begin
          waddr_out = LED_ADDR;
          wdata_out = led_word;
          if (widle) begin
            write_stb  = 1'b1;
            state_next = WR_WAIT;
          end
        end
      end

      WR_WAIT: begin
        if (press) begin
          abort_next = 1'b1;
        end
        if (!settle && widle) begin
          if (wresp != 2'b00) begin
            error_next = 1'b1;
            state_next = RS_REQ;
          end else if (press || abort_pending) begin
            state_next = RS_REQ;
          end else begin
            step_next  = STEP_LAST;
            state_next = HOLD;
          end
        end
      end

      HOLD: begin
        if (press) begin
          state_next = RS_REQ;
        end else if (step_cnt != '0) begin
          step_next = step_cnt - 1'b1;
        end else if (bit_idx != BIT_LAST) begin
          bit_next   = bit_idx + 1'b1;
          state_next = WR_REQ;
        end else begin
          bit_next = '0;
          if (pass_idx == PASS_LAST) begin
            state_next = RS_REQ;
          end else begin
            pass_next  = pass_idx + 1'b1;
            state_next = WR_REQ;
          end
        end
      end

      RS_REQ: begin
        waddr_out = LED_ADDR;
        wdata_out = saved;
        if (widle) begin
          write_stb  = 1'b1;
          state_next = RS_WAIT;
        end
      end

      RS_WAIT: begin
        if (!settle && widle) begin
          if (wresp != 2'b00) begin
            error_next = 1'b1;
          end
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers. Bus addresses and data hold their last driven value between requests.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      bit_idx       <= '0;
      pass_idx      <= '0;
      step_cnt      <= '0;
      saved         <= '0;
      abort_pending <= 1'b0;
      error_q       <= 1'b0;
      settle        <= 1'b0;
      done_q        <= 1'b0;
      raddr_q       <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
    end else begin
      bit_idx       <= bit_next;
      pass_idx      <= pass_next;
      step_cnt      <= step_next;
      saved         <= saved_next;
      abort_pending <= abort_next;
      error_q       <= error_next;
      settle        <= read_stb | write_stb;
      done_q        <= (state != IDLE) && (state_next == IDLE);
      raddr_q       <= raddr_out;
      waddr_q       <= waddr_out;
      wdata_q       <= wdata_out;
    end
  end

  assign AMCI_MOSI = {read_stb, write_stb, raddr_out, wdata_out, waddr_out};
  assign BUSY      = (state != IDLE);
  assign ERROR     = error_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_led_sweep_controller.sv
// Testbench for led_sweep_controller.
// A behavioural AMCI engine answers the DUT's requests. The bench pushes the
// expected LED writes to a scoreboard queue before each press. Each observed
// write strobe pops one entry and compares it.

module tb_led_sweep_controller;

  localparam int          LED_WIDTH       = 4;
  localparam int          PASSES          = 2;
  localparam int          STEP_CYCLES     = 10;
  localparam int          DEBOUNCE_CYCLES = 4;
  localparam logic [31:0] LED_ADDR        = 32'h4000_0000;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        BUTTON;
  logic [97:0] AMCI_MOSI;
  logic [37:0] AMCI_MISO;
  logic        BUSY;
  logic        ERROR;
  logic        DONE;

  logic [31:0] rdata;
  logic        widle;
  logic        ridle;
  logic [1:0]  wresp;
  logic [1:0]  rresp;

  logic [31:0] m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_raddr;
  logic        m_write;
  logic        m_read;

  int          checks        = 0;
  int          errors        = 0;
  int          cycle         = 0;
  int          wr_count      = 0;
  int          rd_count      = 0;
  int          done_count    = 0;
  int          done_wide     = 0;
  int          strobe_wide   = 0;
  int          rd_cycle      = 0;
  int          press_cycle   = 0;
  int          wr_err_target = -1;
  logic        rd_err        = 1'b0;
  logic        busy_at_done  = 1'b1;
  logic [31:0] read_value    = 32'h0000_00A5;
  logic [31:0] sb[$];

  assign AMCI_MISO = {rresp, wresp, ridle, widle, rdata};
  assign m_waddr   = AMCI_MOSI[31:0];
  assign m_wdata   = AMCI_MOSI[63:32];
  assign m_raddr   = AMCI_MOSI[95:64];
  assign m_write   = AMCI_MOSI[96];
  assign m_read    = AMCI_MOSI[97];

  led_sweep_controller #(
    .AXI_DATA_WIDTH  (32),
    .AXI_ADDR_WIDTH  (32),
    .LED_ADDR        (LED_ADDR),
    .LED_WIDTH       (LED_WIDTH),
    .PASSES          (PASSES),
    .STEP_CYCLES     (STEP_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .BUTTON    (BUTTON),
    .AMCI_MOSI (AMCI_MOSI),
    .AMCI_MISO (AMCI_MISO),
    .BUSY      (BUSY),
    .ERROR     (ERROR),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Hold BUTTON high for n rising edges, starting just after a falling edge
  task automatic apply_stimulus(input int n);
    @(negedge CLK);
    BUTTON      = 1'b1;
    press_cycle = cycle;
    repeat (n) @(negedge CLK);
    BUTTON = 1'b0;
  endtask

  // Expected writes for a complete sweep followed by the restore
  task automatic push_full_sweep();
    for (int p = 0; p < PASSES; p++) begin
      for (int b = 0; b < LED_WIDTH; b++) begin
        sb.push_back((read_value & ~32'h0000_000F) | (32'h1 << b));
      end
    end
    sb.push_back(read_value);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int k;
    start = done_count;
    k     = 0;
    while (done_count == start && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check_output(tag, 64'(done_count != start), 64'd1);
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (wr_count < target && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check_output(tag, 64'(wr_count >= target), 64'd1);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESETN = 1'b0;
    @(posedge CLK);
    #3;
    check_output("reset_mosi_zero", 64'(AMCI_MOSI == '0), 64'd1);
    check_output("reset_busy", 64'(BUSY), 64'd0);
    check_output("reset_error", 64'(ERROR), 64'd0);
    check_output("reset_done", 64'(DONE), 64'd0);
    @(negedge CLK);
    RESETN = 1'b1;
  endtask

  // AMCI engine model and output monitor. Inputs change 1 time unit after each rising edge, and outputs are sampled 1 unit later.
  initial begin : engine
    logic       wr_flag;
    logic       rd_flag;
    logic       prev_done;
    logic       prev_write;
    logic       prev_read;
    int         wcnt;
    int         rcnt;
    logic [1:0] pend_wresp;
    wr_flag    = 1'b0;
    rd_flag    = 1'b0;
    prev_done  = 1'b0;
    prev_write = 1'b0;
    prev_read  = 1'b0;
    wcnt       = 0;
    rcnt       = 0;
    pend_wresp = 2'b00;
    widle      = 1'b1;
    ridle      = 1'b1;
    rdata      = '0;
    wresp      = 2'b00;
    rresp      = 2'b00;
    forever begin
      @(posedge CLK);
      #1;
      cycle++;
      if (wr_flag) begin
        widle   = 1'b0;
        wcnt    = 2;
        wr_flag = 1'b0;
      end else if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) begin
          widle = 1'b1;
          wresp = pend_wresp;
        end
      end
      if (rd_flag) begin
        ridle   = 1'b0;
        rcnt    = 2;
        rd_flag = 1'b0;
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          ridle = 1'b1;
          rdata = read_value;
          rresp = rd_err ? 2'b10 : 2'b00;
        end
      end
      #1;
      if (m_write || m_read) begin
        check_output("rw_exclusive", 64'(m_write & m_read), 64'd0);
      end
      if (m_write) begin
        wr_count++;
        if (prev_write) strobe_wide++;
        check_output("waddr", 64'(m_waddr), 64'(LED_ADDR));
        check_output("write_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          check_output("wdata", 64'(m_wdata), 64'(sb.pop_front()));
        end
        pend_wresp = (wr_count == wr_err_target) ? 2'b10 : 2'b00;
        wr_flag    = 1'b1;
      end
      if (m_read) begin
        rd_count++;
        rd_cycle = cycle;
        if (prev_read) strobe_wide++;
        check_output("raddr", 64'(m_raddr), 64'(LED_ADDR));
        rd_flag = 1'b1;
      end
      if (DONE) begin
        done_count++;
        busy_at_done = BUSY;
        if (prev_done) done_wide++;
      end
      prev_done  = DONE;
      prev_write = m_write;
      prev_read  = m_read;
    end
  end

  // Directed test sequence
  initial begin : main
    int base_w;
    int base_r;
    int base_d;
    RESETN = 1'b0;
    BUTTON = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    check_output("reset_mosi_zero", 64'(AMCI_MOSI == '0), 64'd1);
    check_output("reset_busy", 64'(BUSY), 64'd0);
    check_output("reset_error", 64'(ERROR), 64'd0);
    check_output("reset_done", 64'(DONE), 64'd0);
    @(negedge CLK);
    RESETN = 1'b1;

    $display("[TB] glitch shorter than the debounce window");
    apply_stimulus(3);
    repeat (20) @(negedge CLK);
    check_output("glitch_no_read", 64'(rd_count), 64'd0);

    $display("[TB] full sweep");
    push_full_sweep();
    apply_stimulus(6);
    wait_done("sweep_done", 1000);
    check_output("press_to_read_latency", 64'(rd_cycle - press_cycle), 64'(2 + DEBOUNCE_CYCLES + 1));
    check_output("sweep_one_read", 64'(rd_count), 64'd1);
    check_output("sweep_write_count", 64'(wr_count), 64'd9);
    check_output("sweep_done_count", 64'(done_count), 64'd1);
    check_output("sweep_busy_at_done", 64'(busy_at_done), 64'd0);
    check_output("sweep_error", 64'(ERROR), 64'd0);
    check_output("sweep_sb_empty", 64'(sb.size()), 64'd0);
    repeat (20) @(negedge CLK);
    check_output("held_button_no_retrigger", 64'(rd_count), 64'd1);

    $display("[TB] abort during second hold");
    sb.push_back(32'hA1);
    sb.push_back(32'hA2);
    sb.push_back(32'hA5);
    base_w = wr_count;
    apply_stimulus(6);
    wait_writes("abort_second_write", base_w + 2, 500);
    apply_stimulus(6);
    wait_done("abort_done", 500);
    check_output("abort_write_count", 64'(wr_count - base_w), 64'd3);
    check_output("abort_busy_at_done", 64'(busy_at_done), 64'd0);
    check_output("abort_sb_empty", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge CLK);
    check_output("abort_busy_after", 64'(BUSY), 64'd0);
    repeat (20) @(negedge CLK);

    $display("[TB] write response error on third write");
    sb.push_back(32'hA1);
    sb.push_back(32'hA2);
    sb.push_back(32'hA4);
    sb.push_back(32'hA5);
    wr_err_target = wr_count + 3;
    apply_stimulus(6);
    wait_done("werr_done", 1000);
    wr_err_target = -1;
    check_output("werr_error_set", 64'(ERROR), 64'd1);
    check_output("werr_sb_empty", 64'(sb.size()), 64'd0);
    repeat (20) @(negedge CLK);
    push_full_sweep();
    apply_stimulus(6);
    wait_done("after_werr_done", 1000);
    check_output("error_sticky", 64'(ERROR), 64'd1);
    check_output("after_werr_sb_empty", 64'(sb.size()), 64'd0);
    repeat (20) @(negedge CLK);

    $display("[TB] read response error");
    pulse_reset();
    rd_err = 1'b1;
    base_w = wr_count;
    base_r = rd_count;
    apply_stimulus(6);
    wait_done("rerr_done", 500);
    rd_err = 1'b0;
    check_output("rerr_one_read", 64'(rd_count - base_r), 64'd1);
    check_output("rerr_no_writes", 64'(wr_count - base_w), 64'd0);
    check_output("rerr_error_set", 64'(ERROR), 64'd1);
    check_output("rerr_busy_at_done", 64'(busy_at_done), 64'd0);
    repeat (20) @(negedge CLK);

    $display("[TB] reset during hold");
    pulse_reset();
    sb.push_back(32'hA1);
    base_w = wr_count;
    apply_stimulus(6);
    wait_writes("hold_first_write", base_w + 1, 500);
    repeat (6) @(negedge CLK);
    check_output("hold_busy_before_reset", 64'(BUSY), 64'd1);
    pulse_reset();
    base_w = wr_count;
    base_r = rd_count;
    base_d = done_count;
    repeat (60) @(negedge CLK);
    check_output("post_reset_no_writes", 64'(wr_count - base_w), 64'd0);
    check_output("post_reset_no_reads", 64'(rd_count - base_r), 64'd0);
    check_output("post_reset_no_done", 64'(done_count - base_d), 64'd0);
    check_output("post_reset_sb_empty", 64'(sb.size()), 64'd0);

    check_output("done_single_cycle", 64'(done_wide), 64'd0);
    check_output("strobe_single_cycle", 64'(strobe_wide), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin : watchdog
    #500_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/led_sweep_controller.md
# led_sweep_controller

AMCI master that, on a debounced button press, reads the GPIO LED register, sweeps a single lit LED across LED_WIDTH bits for PASSES passes at a programmable step period, then writes back the original register value. It sits in the same slot as the single-flash LED controller and drives the AXI4-Lite master engine through the packed AMCI_MOSI/AMCI_MISO buses. It adds a read-modify-write restore, press-to-abort, sticky error capture and status outputs.

## Interface
- AXI_DATA_WIDTH, 32, AMCI data width.
- AXI_ADDR_WIDTH, 32, AMCI address width.
- LED_ADDR, 32'h4000_0000, AXI address of the GPIO LED register.
- LED_WIDTH, 4, swept bits [LED_WIDTH-1:0]; range 1..AXI_DATA_WIDTH.
- PASSES, 2, full sweeps per press; minimum 1.
- STEP_CYCLES, 25_000_000, clocks each LED stays lit; minimum 1.
- DEBOUNCE_CYCLES, 1_000_000, clocks BUTTON must be stable to register.
- CLK  in  1  clock.
- RESETN  in  1  synchronous, active-low reset; clock CLK.
- BUTTON  in  1  raw asynchronous push-button.
- AMCI_MOSI  out  98  packed, LSB first: waddr[31:0], wdata[63:32], raddr[95:64], write[96], read[97].
- AMCI_MISO  in  38  packed, LSB first: rdata[31:0], widle[32], ridle[33], wresp[35:34], rresp[37:36].
- BUSY  out  1  high from start of sequence until return to IDLE.
- ERROR  out  1  sticky; set on any nonzero wresp/rresp, cleared only by reset.
- DONE  out  1  one-cycle pulse when a sequence (normal or aborted) completes.

## Operation
- BUTTON passes a 2-flop synchronizer, then a debouncer: the debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive clocks. Start/abort event = debounced rising edge.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, HOLD, RS_REQ, RS_WAIT.
- IDLE: on press -> RD_REQ, BUSY=1, bit=0, pass=0.
- RD_REQ: when ridle=1, raddr=LED_ADDR, read=1 for one cycle -> RD_WAIT.
- RD_WAIT: wait one cycle, then for ridle=1; capture saved=rdata. rresp≠0: ERROR=1 -> IDLE with DONE pulse (nothing written). Else -> WR_REQ.
- WR_REQ: when widle=1, waddr=LED_ADDR, wdata=(saved & ~MASK) | (1<<bit), MASK=(1<<LED_WIDTH)-1, write=1 one cycle -> WR_WAIT.
- WR_WAIT: wait one cycle, then for widle=1; wresp≠0: ERROR=1 -> RS_REQ. Else load step counter with STEP_CYCLES-1 -> HOLD.
- HOLD: count down; at 0: if bit<LED_WIDTH-1, bit++ -> WR_REQ; else bit=0, pass++; if pass was PASSES-1 -> RS_REQ, else -> WR_REQ.
- RS_REQ/RS_WAIT: write saved to LED_ADDR, same handshake as WR_REQ/WR_WAIT; wresp≠0 sets ERROR; then -> IDLE, BUSY=0, DONE=1 for one cycle.
- Abort: press while in WR_REQ, WR_WAIT or HOLD: an outstanding write completes first, then -> RS_REQ. Presses in RD_*, RS_* and IDLE-entry cycle are ignored.
- read and write never asserted in the same cycle; at most one AMCI transaction outstanding.

## Timing
- Reset (RESETN=0 at CLK edge): state=IDLE, all AMCI_MOSI fields 0, BUSY=0, ERROR=0, DONE=0, counters 0, debounced level 0. Reset mid-transaction abandons it; no restore write.
- write/read strobes are exactly one cycle wide; addr/data held stable from strobe until next request.
- Press-to-read-strobe latency: 2 (sync) + DEBOUNCE_CYCLES + 1 clocks, with ridle=1.
- Each LED is lit STEP_CYCLES clocks after its write completes, plus write latency before the next.
- Debounced button held high never retriggers; a new press needs release and re-press.
- DONE and the IDLE transition occur in the same cycle.

## Test plan
- LED_WIDTH=4, PASSES=2, STEP_CYCLES=10, DEBOUNCE_CYCLES=4, read returns 0xA5 -> writes 0xA1,0xA2,0xA4,0xA8,0xA1,0xA2,0xA4,0xA8,0xA5 to 0x4000_0000, one DONE pulse, ERROR=0.
- BUTTON high 3 cycles (glitch) -> no read strobe; BUTTON high 6 cycles -> exactly one read strobe.
- Press again during second HOLD of pass 0 -> writes 0xA1,0xA2 then 0xA5, DONE pulse, BUSY=0.
- Engine returns wresp=2 on the third write -> ERROR=1 stays set, next write is restore 0xA5, DONE pulse; later sequence still runs with ERROR=1.
- rresp=2 on initial read -> no writes issued, ERROR=1, DONE pulse.
- RESETN=0 during HOLD -> next cycle all outputs 0, no further AMCI strobes until new press.
